// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory bus between the memory-access stage and data memory
// The unit drives requests through the master modport; the memory answers through slave.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - LC-3 memory-access stage for LD/LDR/LDI/ST/STR/STI
// Indirect ops fetch a pointer at EA first; loads return data and the NZP condition code.
module mem_access_unit #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] ea_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    mem_access_unit_if.master     mem,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic [2:0]            nzp_o
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_IND, S_ACC, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] ea_q, ea_d, sdata_q, sdata_d, ptr_q, ptr_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic                  req_q, req_d, we_q, we_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
    logic [2:0]            nzp_q, nzp_d;
    logic                  accept, xfer, timeout;

    // req_q is high exactly in IND/ACC, so it doubles as the "transaction open" flag
    assign accept  = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign xfer    = req_q && mem.ready;
    assign timeout = (TIMEOUT_CYCLES != 0) && req_q && !mem.ready
                     && (wait_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ea_q    <= '0;
            sdata_q <= '0;
            ptr_q   <= '0;
            wait_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            nzp_q   <= 3'b010;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ea_q    <= ea_d;
            sdata_q <= sdata_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            nzp_q   <= nzp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = accept ? (op_i[0] ? S_IND : S_ACC) : S_IDLE;
            S_IND: begin
                if (xfer)         state_d = S_ACC;
                else if (timeout) state_d = S_DONE;
            end
            S_ACC: begin
                if (xfer || timeout) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop
    always_comb begin
        op_d    = op_q;
        ea_d    = ea_q;
        sdata_d = sdata_q;
        ptr_d   = ptr_q;
        load_d  = load_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            op_d    = op_i;
            ea_d    = ea_i;
            sdata_d = store_data_i;
        end
        if (state_q == S_IND && xfer) ptr_d = mem.rdata;
        if (state_q == S_ACC && xfer && !op_q[1]) load_d = mem.rdata;
        if (xfer || timeout) wait_d = '0;
        else if (req_q)      wait_d = wait_q + CW'(1);

        req_d  = (state_d == S_IND) || (state_d == S_ACC);
        busy_d = req_d;
        done_d = (state_d == S_DONE);
        err_d  = timeout;
        we_d   = (state_d == S_ACC) && op_d[1];
        if (state_d == S_IND)      addr_d = ea_d;
        else if (state_d == S_ACC) addr_d = op_d[0] ? ptr_d : ea_d;
        if (state_d == S_ACC)      wdata_d = sdata_d;

        if (load_d[DATA_WIDTH-1]) nzp_d = 3'b100;
        else if (load_d == '0)    nzp_d = 3'b010;
        else                      nzp_d = 3'b001;
    end

    assign mem.req     = req_q;
    assign mem.we      = we_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign load_data_o = load_q;
    assign nzp_o       = nzp_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit with a behavioural data memory
// The memory completes any request in a cycle where ready is high.
module tb_mem_access_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] ea;
    logic [15:0] sdata;
    logic        busy, done, err;
    logic [15:0] load_data;
    logic [2:0]  nzp;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rd0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] mem_arr [logic [15:0]];

    mem_access_unit_if #(.DATA_WIDTH(16)) mem_if ();

    mem_access_unit #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .op_i         (op),
        .ea_i         (ea),
        .store_data_i (sdata),
        .mem          (mem_if.master),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .load_data_o  (load_data),
        .nzp_o        (nzp)
    );

    function automatic logic [15:0] rd_word(input logic [15:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : 16'h0000;
    endfunction

    assign mem_if.rdata = rd_word(mem_if.addr);

    always @(posedge clk) begin
        if (mem_if.req && mem_if.ready) begin
            if (mem_if.we) begin
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mem_if.addr;
                wr_data <= mem_if.wdata;
                mem_arr[mem_if.addr] = mem_if.wdata;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; ea = '0; sdata = '0;
        mem_if.ready = 1'b1;
        mem_arr[16'h3000] = 16'h8001;
        mem_arr[16'h3002] = 16'h5000;
        mem_arr[16'h3004] = 16'h0005;
        mem_arr[16'h4000] = 16'h0000;
        tick(); tick();
        chk_b("rst_req", mem_if.req, 1'b0);
        chk_b("rst_we", mem_if.we, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_err", err, 1'b0);
        chk_w("rst_addr", mem_if.addr, 16'h0000);
        chk_w("rst_wdata", mem_if.wdata, 16'h0000);
        chk_w("rst_load", load_data, 16'h0000);
        chk_w("rst_nzp", 16'(nzp), 16'h0002);
        rst = 1'b0;
        tick();

        // LD 3000 -> 8001, zero wait
        start = 1'b1; op = 2'b00; ea = 16'h3000;
        tick();
        start = 1'b0;
        chk_b("ld_c1_req", mem_if.req, 1'b1);
        chk_w("ld_c1_addr", mem_if.addr, 16'h3000);
        chk_b("ld_c1_we", mem_if.we, 1'b0);
        chk_b("ld_c1_busy", busy, 1'b1);
        chk_b("ld_c1_done", done, 1'b0);
        tick();
        chk_b("ld_c2_done", done, 1'b1);
        chk_b("ld_c2_err", err, 1'b0);
        chk_b("ld_c2_req", mem_if.req, 1'b0);
        chk_b("ld_c2_busy", busy, 1'b0);
        chk_w("ld_load", load_data, 16'h8001);
        chk_w("ld_nzp", 16'(nzp), 16'h0004);
        tick();
        chk_b("ld_idle_done", done, 1'b0);

        // STI 3002 -> pointer 5000, write 1234
        start = 1'b1; op = 2'b11; ea = 16'h3002; sdata = 16'h1234;
        tick();
        start = 1'b0;
        chk_w("sti_c1_addr", mem_if.addr, 16'h3002);
        chk_b("sti_c1_we", mem_if.we, 1'b0);
        tick();
        chk_b("sti_c2_req", mem_if.req, 1'b1);
        chk_w("sti_c2_addr", mem_if.addr, 16'h5000);
        chk_b("sti_c2_we", mem_if.we, 1'b1);
        chk_w("sti_c2_wdata", mem_if.wdata, 16'h1234);
        tick();
        chk_b("sti_c3_done", done, 1'b1);
        chk_w("sti_wr_addr", wr_addr, 16'h5000);
        chk_w("sti_wr_data", wr_data, 16'h1234);
        chk_w("sti_load", load_data, 16'h8001);
        chk_w("sti_nzp", 16'(nzp), 16'h0004);

        // back-to-back ST accepted in the DONE cycle
        start = 1'b1; op = 2'b10; ea = 16'h3100; sdata = 16'hBEEF;
        tick();
        start = 1'b0;
        chk_b("b2b_req", mem_if.req, 1'b1);
        chk_b("b2b_we", mem_if.we, 1'b1);
        chk_w("b2b_addr", mem_if.addr, 16'h3100);
        chk_w("b2b_wdata", mem_if.wdata, 16'hBEEF);
        tick();
        chk_b("b2b_done", done, 1'b1);
        chk_w("b2b_wr_addr", wr_addr, 16'h3100);
        chk_w("b2b_wr_data", wr_data, 16'hBEEF);
        chk_w("b2b_wr_cnt", 16'(wr_cnt), 16'd2);
        tick();

        // LDI 3000 -> pointer 4000 -> 0000
        mem_arr[16'h3000] = 16'h4000;
        rd0 = rd_cnt;
        start = 1'b1; op = 2'b01; ea = 16'h3000;
        tick();
        start = 1'b0;
        chk_w("ldi_c1_addr", mem_if.addr, 16'h3000);
        chk_b("ldi_c1_we", mem_if.we, 1'b0);
        tick();
        chk_b("ldi_c2_req", mem_if.req, 1'b1);
        chk_w("ldi_c2_addr", mem_if.addr, 16'h4000);
        tick();
        chk_b("ldi_c3_done", done, 1'b1);
        chk_w("ldi_load", load_data, 16'h0000);
        chk_w("ldi_nzp", 16'(nzp), 16'h0002);
        chk_w("ldi_reads", 16'(rd_cnt - rd0), 16'd2);
        tick();

        // LD 3004 with ready low three cycles and a START pulse while busy
        mem_if.ready = 1'b0;
        start = 1'b1; op = 2'b00; ea = 16'h3004;
        tick();
        start = 1'b0;
        chk_w("wait_c1_addr", mem_if.addr, 16'h3004);
        tick();
        start = 1'b1; op = 2'b01; ea = 16'h1111;
        chk_b("wait_c2_req", mem_if.req, 1'b1);
        tick();
        start = 1'b0;
        chk_w("wait_c3_addr", mem_if.addr, 16'h3004);
        chk_b("wait_c3_done", done, 1'b0);
        tick();
        mem_if.ready = 1'b1;
        chk_b("wait_c4_req", mem_if.req, 1'b1);
        chk_w("wait_c4_addr", mem_if.addr, 16'h3004);
        tick();
        chk_b("wait_c5_done", done, 1'b1);
        chk_b("wait_c5_err", err, 1'b0);
        chk_w("wait_load", load_data, 16'h0005);
        chk_w("wait_nzp", 16'(nzp), 16'h0001);
        tick();
        chk_b("wait_idle_busy", busy, 1'b0);
        chk_b("wait_idle_done", done, 1'b0);

        // timeout: ready never asserted, limit 4 wait cycles
        mem_if.ready = 1'b0;
        start = 1'b1; op = 2'b00; ea = 16'h3000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            start = 1'b0;
            chk_b($sformatf("to_c%0d_req", i), mem_if.req, 1'b1);
        end
        tick();
        chk_b("to_req", mem_if.req, 1'b0);
        chk_b("to_done", done, 1'b1);
        chk_b("to_err", err, 1'b1);
        chk_b("to_busy", busy, 1'b0);
        chk_w("to_load", load_data, 16'h0005);
        chk_w("to_nzp", 16'(nzp), 16'h0001);
        tick();
        chk_b("to_after_done", done, 1'b0);

        // reset while an LDI sits in IND
        start = 1'b1; op = 2'b01; ea = 16'h3000;
        tick();
        start = 1'b0;
        chk_b("rmid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk_b("rmid_req", mem_if.req, 1'b0);
        chk_b("rmid_busy0", busy, 1'b0);
        chk_b("rmid_done", done, 1'b0);
        chk_w("rmid_nzp", 16'(nzp), 16'h0002);
        chk_w("rmid_load", load_data, 16'h0000);
        rst = 1'b0;
        mem_if.ready = 1'b1;
        tick();
        chk_b("rmid_after_done", done, 1'b0);
        chk_b("rmid_after_req", mem_if.req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
